// File: rtl/bpu_ras_dual.sv
// ----------------------------------------------------------------------------
// bpu_ras_dual
//
// Return address stack for the branch prediction unit. Two circular stacks
// are kept side by side:
//   - a speculative stack, pushed/popped by the predict stage, whose top
//     supplies the predicted target of ret slots;
//   - an architectural stack, updated by up to NRET retiring call/ret
//     instructions per cycle, applied in lane order.
// A flush copies the architectural stack (including this cycle's commits)
// over the speculative one, so wrong-path calls/rets never leak into later
// predictions.
//
// Each stack is a storage array, a wrapping pointer to the next free slot and
// an occupancy count that saturates at DEPTH. Pushing onto a full stack
// silently overwrites the oldest entry; popping an empty stack is ignored.
// A push and pop in the same operation pops first, then pushes.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   spec_push_i          predicted call, pushes spec_push_addr_i
//   spec_pop_i           predicted ret, pops the top
//   spec_push_addr_i     return address to push speculatively
//   commit_valid_i       per lane: retiring control-flow instruction
//   commit_is_call_i     per lane: it is a call (pushes pc + INSTR_BYTES)
//   commit_is_ret_i      per lane: it is a return (pops)
//   commit_pc_i          per lane: pc of the retiring instruction
//   flush_i              restore speculative stack from architectural
//   top_valid_o          speculative stack non-empty
//   top_addr_o           speculative top entry, 0 when empty
//   spec_count_o         speculative occupancy
//   arch_count_o         architectural occupancy
//
// Optional feature, macro BPU_RAS_STATS_EN:
//   spec_ovf_cnt_o       speculative pushes made while full (saturating)
//   spec_udf_cnt_o       speculative pops made while empty (saturating)
// ----------------------------------------------------------------------------
module bpu_ras_dual #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 16,
  parameter int NRET        = 2,
  parameter int INSTR_BYTES = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         spec_push_i,
  input  logic                         spec_pop_i,
  input  logic [XLEN-1:0]              spec_push_addr_i,
  input  logic [NRET-1:0]              commit_valid_i,
  input  logic [NRET-1:0]              commit_is_call_i,
  input  logic [NRET-1:0]              commit_is_ret_i,
  input  logic [NRET-1:0][XLEN-1:0]    commit_pc_i,
  input  logic                         flush_i,
`ifdef BPU_RAS_STATS_EN
  output logic [31:0]                  spec_ovf_cnt_o,
  output logic [31:0]                  spec_udf_cnt_o,
`endif
  output logic                         top_valid_o,
  output logic [XLEN-1:0]              top_addr_o,
  output logic [$clog2(DEPTH+1)-1:0]   spec_count_o,
  output logic [$clog2(DEPTH+1)-1:0]   arch_count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0]   DepthCnt = CW'(DEPTH);
  localparam logic [XLEN-1:0] RetOfs   = XLEN'(INSTR_BYTES);

  // Speculative stack state
  logic [XLEN-1:0] specMem_q [DEPTH];
  logic [XLEN-1:0] specMem_d [DEPTH];
  logic [PW-1:0]   specPtr_q, specPtr_d;
  logic [CW-1:0]   specCnt_q, specCnt_d;

  // Architectural stack state
  logic [XLEN-1:0] archMem_q [DEPTH];
  logic [XLEN-1:0] archMem_d [DEPTH];
  logic [PW-1:0]   archPtr_q, archPtr_d;
  logic [CW-1:0]   archCnt_q, archCnt_d;

  logic [PW-1:0]   topIdx;

  // Architectural next state: lanes are folded in sequentially, lane 0 first,
  // so a later lane sees the stack as left by the earlier ones. Each lane
  // pops before it pushes, which makes call+ret on one lane a top replace.
  always_comb begin
    archMem_d = archMem_q;
    archPtr_d = archPtr_q;
    archCnt_d = archCnt_q;
    for (int l = 0; l < NRET; l++) begin
      if (commit_valid_i[l]) begin
        if (commit_is_ret_i[l] && (archCnt_d != '0)) begin
          archPtr_d = archPtr_d - 1'b1;
          archCnt_d = archCnt_d - 1'b1;
        end
        if (commit_is_call_i[l]) begin
          archMem_d[archPtr_d] = commit_pc_i[l] + RetOfs;
          archPtr_d            = archPtr_d + 1'b1;
          if (archCnt_d != DepthCnt) begin
            archCnt_d = archCnt_d + 1'b1;
          end
        end
      end
    end
  end

  // Speculative next state. A flush takes the architectural next state, so
  // commits retiring in the flush cycle are not lost, and the predict-stage
  // request of that cycle is dropped because it belongs to the wrong path.
  always_comb begin
    specMem_d = specMem_q;
    specPtr_d = specPtr_q;
    specCnt_d = specCnt_q;
    if (flush_i) begin
      specMem_d = archMem_d;
      specPtr_d = archPtr_d;
      specCnt_d = archCnt_d;
    end else begin
      if (spec_pop_i && (specCnt_q != '0)) begin
        specPtr_d = specPtr_d - 1'b1;
        specCnt_d = specCnt_d - 1'b1;
      end
      if (spec_push_i) begin
        specMem_d[specPtr_d] = spec_push_addr_i;
        specPtr_d            = specPtr_d + 1'b1;
        if (specCnt_d != DepthCnt) begin
          specCnt_d = specCnt_d + 1'b1;
        end
      end
    end
  end

  // State registers for both stacks; reset clears storage too so the
  // stale-entry contents are deterministic after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        specMem_q[i] <= '0;
        archMem_q[i] <= '0;
      end
      specPtr_q <= '0;
      specCnt_q <= '0;
      archPtr_q <= '0;
      archCnt_q <= '0;
    end else begin
      specMem_q <= specMem_d;
      specPtr_q <= specPtr_d;
      specCnt_q <= specCnt_d;
      archMem_q <= archMem_d;
      archPtr_q <= archPtr_d;
      archCnt_q <= archCnt_d;
    end
  end

  // Outputs come only from registered speculative state: no bypass of the
  // current cycle's push/pop.
  assign topIdx       = specPtr_q - 1'b1;
  assign top_valid_o  = (specCnt_q != '0);
  assign top_addr_o   = top_valid_o ? specMem_q[topIdx] : '0;
  assign spec_count_o = specCnt_q;
  assign arch_count_o = archCnt_q;

`ifdef BPU_RAS_STATS_EN
  logic [31:0] ovfCnt_q, ovfCnt_d;
  logic [31:0] udfCnt_q, udfCnt_d;
  logic        ovfEvent;
  logic        udfEvent;

  // An overflow is a push that really overwrites the oldest entry; a
  // push+pop on a full stack only replaces the top, so it is not counted.
  // Likewise a push+pop on an empty stack is a plain push, not an underflow.
  assign ovfEvent = !flush_i && spec_push_i && !spec_pop_i && (specCnt_q == DepthCnt);
  assign udfEvent = !flush_i && spec_pop_i && !spec_push_i && (specCnt_q == '0);

  // Saturating event counters; flush leaves them alone.
  always_comb begin
    ovfCnt_d = ovfCnt_q;
    udfCnt_d = udfCnt_q;
    if (ovfEvent && (ovfCnt_q != '1)) begin
      ovfCnt_d = ovfCnt_q + 32'd1;
    end
    if (udfEvent && (udfCnt_q != '1)) begin
      udfCnt_d = udfCnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovfCnt_q <= '0;
      udfCnt_q <= '0;
    end else begin
      ovfCnt_q <= ovfCnt_d;
      udfCnt_q <= udfCnt_d;
    end
  end

  assign spec_ovf_cnt_o = ovfCnt_q;
  assign spec_udf_cnt_o = udfCnt_q;
`endif

endmodule

// File: doc/bpu_ras_dual.md
Name: bpu_ras_dual

Overview:
- Parametrised return address stack for the BPU, generalising the single-update RAS path to NRET commit lanes and configurable depth.
- Keeps two circular stacks:
  - a speculative stack, driven by the predict stage, which supplies ret targets;
  - an architectural stack, driven by retiring call/ret instructions.
- On flush the speculative stack is restored from the architectural stack, so mispredicted call/ret sequences cannot corrupt later predictions.
- Sits inside bpu, beside the BTB/BHT; its top feeds pred_slot_target selection for ret slots.

Parameters:
- XLEN, 32, address width.
- DEPTH, 16, entries per stack; power of two, at least 2.
- NRET, 2, commit lanes per cycle, at least 1.
- INSTR_BYTES, 4, call-to-return-address offset.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- spec_push_i  in  1  predicted call: push spec_push_addr_i
- spec_pop_i  in  1  predicted ret: pop top
- spec_push_addr_i  in  XLEN  return address to push
- commit_valid_i  in  NRET  lane retires a control-flow instruction
- commit_is_call_i  in  NRET  lane is a call
- commit_is_ret_i  in  NRET  lane is a return
- commit_pc_i  in  NRET x XLEN  pc of the retiring instruction
- flush_i  in  1  pipeline flush: restore speculative from architectural
- top_valid_o  out  1  speculative stack non-empty
- top_addr_o  out  XLEN  speculative top entry; 0 when empty
- spec_count_o  out  $clog2(DEPTH+1)  speculative occupancy
- arch_count_o  out  $clog2(DEPTH+1)  architectural occupancy

Behaviour:
- Stack state: each stack has storage[DEPTH], a ptr of $clog2(DEPTH) bits that wraps modulo DEPTH, and a count that saturates at DEPTH.
  - Top = storage[ptr-1].
- Reset, asynchronous on rst_ni low:
  - all ptrs, counts and storage = 0;
  - outputs: top_valid_o=0, top_addr_o=0, spec_count_o=0, arch_count_o=0.
  - Reset asserted mid-operation discards all in-flight updates.
- Outputs are combinational from registered speculative state only. An update in cycle N is visible in cycle N+1; there is no same-cycle bypass.
- Push:
  - storage[ptr] = addr; ptr += 1; count = min(count+1, DEPTH).
  - Push when full overwrites the oldest entry; ptr wraps; count stays at DEPTH.
- Pop:
  - when count > 0: ptr -= 1, count -= 1; storage is not cleared;
  - pop when empty: no state change (underflow ignored).
- Push and pop in the same op (coroutine-style jalr): pop first, then push. When non-empty the top is replaced and count is unchanged; when empty this is a plain push.
- Speculative update, flush_i=0: one op per cycle from spec_push_i / spec_pop_i with the rules above.
- Commit update: lanes are applied sequentially, lane 0 first, within a single cycle.
  - A lane participates only when commit_valid_i is set.
  - call pushes commit_pc_i + INSTR_BYTES, truncated to XLEN, wrapping at 2^XLEN.
  - ret pops.
  - call and ret together: pop then push.
  - Valid with neither flag: no-op.
- Flush, flush_i=1:
  - speculative storage/ptr/count := the architectural next state, i.e. including this cycle's commit updates;
  - spec_push_i / spec_pop_i are ignored that cycle;
  - flush with no commit simply copies the current architectural state.
- Non-participating lanes: commit lanes with commit_valid_i=0 have no effect regardless of their flags.

Optional Feature:
- Macro: BPU_RAS_STATS_EN.
- When defined, two extra outputs are added:
  - spec_ovf_cnt_o (32 bits): counts speculative pushes made while full;
  - spec_udf_cnt_o (32 bits): counts speculative pops made while empty (a push+pop while empty is not counted).
  - Both counters saturate at all-ones, reset to 0, and are not affected by flush.
- When undefined, these ports and counters are absent and all other behaviour is identical.

Test Plan:
- Reset then idle -> top_valid_o=0, top_addr_o=0, both counts 0.
- Speculative push of 0x100, 0x200, 0x300 on consecutive cycles, then pop -> top_addr_o=0x300 the cycle after the third push, 0x200 after the pop, spec_count_o=2.
- DEPTH=16:
  - push 17 addresses 0x1000+4*i (i=0..16) -> spec_count_o=16, top=0x1040;
  - then 16 pops -> the final pop exposes an empty stack, top_valid_o=0 (entry 0x1000 was overwritten);
  - with BPU_RAS_STATS_EN: spec_ovf_cnt_o=1.
- Commit, NRET=2, same cycle:
  - lane0 call pc=0x8000_0000, lane1 call pc=0x8000_0010 -> arch_count_o=2;
  - next cycle flush_i=1 -> following cycle top_addr_o=0x8000_0014, spec_count_o=2.
- Flush with simultaneous commit:
  - spec stack holds 5 bogus pushes; commit lane0 ret on an arch stack of {0x40, 0x80} together with flush_i=1 and spec_push_i=1 -> next cycle spec_count_o=1, top=0x40; the spec push is ignored.
- Same-op push+pop:
  - spec top=0x500, spec_push_i=spec_pop_i=1, addr=0x600 -> top=0x600, count unchanged;
  - on an empty stack the same op -> count=1;
  - spec_pop_i alone on an empty stack -> no change; with BPU_RAS_STATS_EN, spec_udf_cnt_o increments.
